// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: command encodings, arbiter state encoding and
// default bus widths used by the arbiter, its selector and requester interface.
package mem_bus_pkg;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam int unsigned AW_DEFAULT = 9;
   localparam int unsigned DW_DEFAULT = 16;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StWr     = 2'b01,
      StRdAddr = 2'b10,
      StRdData = 2'b11
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: request/command payload towards the
// arbiter, grant plus registered read return back to the requester.
interface mem_arbiter_if
   import mem_bus_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT,
   parameter int unsigned DW = DW_DEFAULT
);

   logic          req;
   logic [1:0]    cmd;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, cmd, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, cmd, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/rr_pick.sv
// Two-requester selector (bit 0 = A, bit 1 = B) with a last-grant pointer.
// Round-robin on ties unless FIXED_PRIO, in which case A always wins.
module rr_pick #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       free,
   output logic [1:0] gnt
);

   logic last_b;

   always_comb begin
      gnt = 2'b00;
      if (free) begin
         if (req == 2'b01) begin
            gnt = 2'b01;
         end else if (req == 2'b10) begin
            gnt = 2'b10;
         end else if (req == 2'b11) begin
            gnt = (FIXED_PRIO || last_b) ? 2'b01 : 2'b10;
         end
      end
   end

   // gnt is only ever raised for a requesting port, so any grant is a transfer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_b <= 1'b1;
      end else if (|gnt) begin
         last_b <= gnt[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two masters onto the shared registered memory bus and returns
// each master its own registered read data after the RAM's one-cycle latency.
module mem_arbiter
   import mem_bus_pkg::*;
#(
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned AW         = AW_DEFAULT,
   parameter int unsigned DW         = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  a,
   mem_arbiter_if.slave  b,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] write_data,
   input  logic [DW-1:0] read_data
);

   arb_state_e    state;
   logic          owner_b;
   logic          free;
   logic [1:0]    gnt;
   logic          win_b;
   logic [1:0]    sel_cmd;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          a_rvalid_q, b_rvalid_q;
   logic [DW-1:0] a_rdata_q, b_rdata_q;

   assign free = (state != StRdAddr);

   rr_pick #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_pick (
      .clk  (clk),
      .reset(reset),
      .req  ({b.req, a.req}),
      .free (free),
      .gnt  (gnt)
   );

   assign a.gnt     = gnt[0];
   assign b.gnt     = gnt[1];
   assign win_b     = gnt[1];
   assign sel_cmd   = win_b ? b.cmd   : a.cmd;
   assign sel_addr  = win_b ? b.addr  : a.addr;
   assign sel_wdata = win_b ? b.wdata : a.wdata;

   assign a.rvalid = a_rvalid_q;
   assign a.rdata  = a_rdata_q;
   assign b.rvalid = b_rvalid_q;
   assign b.rdata  = b_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         owner_b    <= 1'b0;
         mem_cmd    <= MNONE;
         mem_addr   <= '0;
         write_data <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;

         if (state == StRdData) begin
            if (owner_b) begin
               b_rdata_q  <= read_data;
               b_rvalid_q <= 1'b1;
            end else begin
               a_rdata_q  <= read_data;
               a_rvalid_q <= 1'b1;
            end
         end

         if (state == StRdAddr) begin
            // MREAD/address stay on the bus so the RAM read enable spans the data cycle
            state <= StRdData;
         end else if ((|gnt) && (sel_cmd == MWRITE || sel_cmd == MREAD)) begin
            owner_b    <= win_b;
            state      <= (sel_cmd == MWRITE) ? StWr : StRdAddr;
            mem_cmd    <= sel_cmd;
            mem_addr   <= sel_addr;
            write_data <= sel_wdata;
         end else begin
            // idle cycle or accepted no-op command
            if (|gnt) begin
               owner_b <= win_b;
            end
            state      <= StIdle;
            mem_cmd    <= MNONE;
            mem_addr   <= '0;
            write_data <= '0;
         end
      end
   end

endmodule
